// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the instruction/data memory arbiter: FSM state
// encoding, requester IDs and memory-latency bounds.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic REQ_INST = 1'b0;
    localparam logic REQ_DATA = 1'b1;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 7;
    localparam int CNT_W       = 3;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2
// Combinational two-way round-robin picker.
// Ports:
//   req[1:0]  requests, bit 0 = instruction fetch, bit 1 = data
//   last      ID of the requester served most recently
//   gnt[1:0]  one-hot grant (all zero when nothing is requested)
//   winner    ID of the granted requester
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       winner
);

    always_comb begin
        gnt    = 2'b00;
        winner = REQ_INST;
        case (req)
            2'b01: begin
                gnt    = 2'b01;
                winner = REQ_INST;
            end
            2'b10: begin
                gnt    = 2'b10;
                winner = REQ_DATA;
            end
            2'b11: begin
                // On conflict the requester not served last wins.
                winner = (last == REQ_INST) ? REQ_DATA : REQ_INST;
                gnt    = (winner == REQ_DATA) ? 2'b10 : 2'b01;
            end
            default: begin
                gnt    = 2'b00;
                winner = REQ_INST;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port synchronous memory between the instruction-fetch
// port and the load/store port of a multicycle core. One access is
// outstanding at a time; conflicts are resolved round-robin. Read data is
// returned MEM_LAT cycles after the memory command strobe.
// Ports:
//   i_clk, i_rst                       clock, asynchronous active-high reset
//   i_i_req/i_i_addr                   fetch request and byte address
//   o_i_gnt/o_i_rvalid/o_i_rdata       fetch grant, read-data pulse, data
//   i_d_req/i_d_we/i_d_addr/i_d_wdata  load/store request
//   o_d_gnt/o_d_rvalid/o_d_rdata       data grant, load-data pulse, data
//   o_m_cs/o_m_we/o_m_addr/o_m_wdata   memory command (zero while idle)
//   i_m_rdata                          memory read data
//   o_busy                             high whenever the FSM is not IDLE
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_LAT    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_i_req,
    input  logic [ADDR_WIDTH-1:0] i_i_addr,
    output logic                  o_i_gnt,
    output logic                  o_i_rvalid,
    output logic [DATA_WIDTH-1:0] o_i_rdata,
    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [ADDR_WIDTH-1:0] i_d_addr,
    input  logic [DATA_WIDTH-1:0] i_d_wdata,
    output logic                  o_d_gnt,
    output logic                  o_d_rvalid,
    output logic [DATA_WIDTH-1:0] o_d_rdata,
    output logic                  o_m_cs,
    output logic                  o_m_we,
    output logic [ADDR_WIDTH-1:0] o_m_addr,
    output logic [DATA_WIDTH-1:0] o_m_wdata,
    input  logic [DATA_WIDTH-1:0] i_m_rdata,
    output logic                  o_busy
);

    // WAIT counts down from MEM_LAT-1 to 0; data is valid on the zero cycle.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t                  state;
    logic                    last;
    logic [CNT_W-1:0]        cnt;
    logic                    id_r;
    logic                    we_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [DATA_WIDTH-1:0]   i_rdata_r;
    logic [DATA_WIDTH-1:0]   d_rdata_r;

    logic [1:0]              pick_gnt;
    logic                    pick_id;
    logic                    grant_ok;

    rr_arb2 u_rr_arb2 (
        .req    ({i_d_req, i_i_req}),
        .last   (last),
        .gnt    (pick_gnt),
        .winner (pick_id)
    );

    // Grants are only offered from IDLE, and are masked while reset is
    // asserted so every output reads zero during reset.
    assign grant_ok = (state == IDLE) && !i_rst;
    assign o_i_gnt  = grant_ok && pick_gnt[0];
    assign o_d_gnt  = grant_ok && pick_gnt[1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            last      <= REQ_INST;
            cnt       <= '0;
            id_r      <= REQ_INST;
            we_r      <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            i_rdata_r <= '0;
            d_rdata_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_gnt != 2'b00) begin
                        id_r    <= pick_id;
                        last    <= pick_id;
                        addr_r  <= (pick_id == REQ_DATA) ? i_d_addr : i_i_addr;
                        we_r    <= (pick_id == REQ_DATA) && i_d_we;
                        wdata_r <= (pick_id == REQ_DATA) ? i_d_wdata : '0;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_r) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= CNT_LOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        if (id_r == REQ_DATA) begin
                            d_rdata_r <= i_m_rdata;
                        end else begin
                            i_rdata_r <= i_m_rdata;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory command is driven only during ACCESS; all fields read zero
    // otherwise.
    assign o_m_cs     = (state == ACCESS);
    assign o_m_we     = o_m_cs && we_r;
    assign o_m_addr   = o_m_cs ? addr_r  : '0;
    assign o_m_wdata  = o_m_cs ? wdata_r : '0;

    assign o_i_rvalid = (state == RESP) && (id_r == REQ_INST);
    assign o_d_rvalid = (state == RESP) && (id_r == REQ_DATA);
    assign o_i_rdata  = i_rdata_r;
    assign o_d_rdata  = d_rdata_r;
    assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Scoreboard bench for mem_arbiter. Three instances with MEM_LAT = 1, 2, 7
// share one clock and reset; each scenario drives one instance while the
// others stay idle. Expected memory commands and read responses are queued
// by the stimulus and consumed by a negedge monitor.
module tb_mem_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        i_req   [N];
    logic [31:0] i_addr  [N];
    logic        d_req   [N];
    logic        d_we    [N];
    logic [31:0] d_addr  [N];
    logic [31:0] d_wdata [N];
    logic        i_gnt   [N];
    logic        i_rv    [N];
    logic [31:0] i_rd    [N];
    logic        d_gnt   [N];
    logic        d_rv    [N];
    logic [31:0] d_rd    [N];
    logic        m_cs    [N];
    logic        m_we    [N];
    logic [31:0] m_addr  [N];
    logic [31:0] m_wdata [N];
    logic [31:0] m_rdata [N];
    logic        busy    [N];

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          inst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          at;
    } cmd_t;

    typedef struct {
        int          inst;
        logic        port;   // 0 = fetch, 1 = data
        logic [31:0] data;
        int          at;
    } rv_t;

    cmd_t cmd_q[$];
    rv_t  rv_q[$];

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : 7;
    endfunction

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h10) return 32'h8C010004;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic void chk(input bit ok, input string name, input int g,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s inst=%0d cycle=%0d got=%h want=%h", name, g, cyc, act, exp);
        end
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_arbiter #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .MEM_LAT    ((g == 0) ? 1 : (g == 1) ? 2 : 7)
        ) u_dut (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_i_req    (i_req[g]),
            .i_i_addr   (i_addr[g]),
            .o_i_gnt    (i_gnt[g]),
            .o_i_rvalid (i_rv[g]),
            .o_i_rdata  (i_rd[g]),
            .i_d_req    (d_req[g]),
            .i_d_we     (d_we[g]),
            .i_d_addr   (d_addr[g]),
            .i_d_wdata  (d_wdata[g]),
            .o_d_gnt    (d_gnt[g]),
            .o_d_rvalid (d_rv[g]),
            .o_d_rdata  (d_rd[g]),
            .o_m_cs     (m_cs[g]),
            .o_m_we     (m_we[g]),
            .o_m_addr   (m_addr[g]),
            .o_m_wdata  (m_wdata[g]),
            .i_m_rdata  (m_rdata[g]),
            .o_busy     (busy[g])
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data is presented only in the single cycle at whose
    // end the arbiter must sample it (cycle 1+L after the command cycle).
    int          lat_cnt [N];
    logic [31:0] rd_addr [N];

    always @(posedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (m_cs[g] && !m_we[g]) begin
                lat_cnt[g] <= lat_of(g);
                rd_addr[g] <= m_addr[g];
            end else if (lat_cnt[g] > 0) begin
                lat_cnt[g] <= lat_cnt[g] - 1;
            end
        end
    end

    always_comb begin
        for (int g = 0; g < N; g++) begin
            m_rdata[g] = (lat_cnt[g] == 1) ? memf(rd_addr[g]) : 32'hBAD0BAD0;
        end
    end

    // Monitor: consumes scoreboard entries whenever a DUT presents a memory
    // command or a read response.
    always @(negedge clk) begin
        cmd_t c;
        rv_t  r;
        for (int g = 0; g < N; g++) begin
            if (m_cs[g]) begin
                chk(cmd_q.size() > 0, "cmd_unexpected", g, m_addr[g], 32'h0);
                if (cmd_q.size() > 0) begin
                    c = cmd_q.pop_front();
                    chk(c.inst == g, "cmd_inst", g, 32'(g), 32'(c.inst));
                    chk(c.at == cyc, "cmd_cycle", g, 32'(cyc), 32'(c.at));
                    chk(m_we[g] == c.we, "cmd_we", g, 32'(m_we[g]), 32'(c.we));
                    chk(m_addr[g] == c.addr, "cmd_addr", g, m_addr[g], c.addr);
                    chk(m_wdata[g] == c.wdata, "cmd_wdata", g, m_wdata[g], c.wdata);
                end
            end else begin
                chk(!m_we[g] && m_addr[g] == 32'h0 && m_wdata[g] == 32'h0,
                    "mem_idle_zero", g, m_addr[g] | m_wdata[g], 32'h0);
            end
            if (i_rv[g] || d_rv[g]) begin
                chk(!(i_rv[g] && d_rv[g]), "rv_both", g, 32'h3, 32'h1);
                chk(rv_q.size() > 0, "rv_unexpected", g, 32'(d_rv[g]), 32'h0);
                if (rv_q.size() > 0) begin
                    r = rv_q.pop_front();
                    chk(r.inst == g, "rv_inst", g, 32'(g), 32'(r.inst));
                    chk(d_rv[g] == r.port, "rv_port", g, 32'(d_rv[g]), 32'(r.port));
                    chk(r.at == cyc, "rv_cycle", g, 32'(cyc), 32'(r.at));
                    chk((d_rv[g] ? d_rd[g] : i_rd[g]) == r.data, "rv_data", g,
                        d_rv[g] ? d_rd[g] : i_rd[g], r.data);
                end
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic check_zero(input int g);
        chk({i_gnt[g], d_gnt[g], i_rv[g], d_rv[g], m_cs[g], m_we[g], busy[g]} == 7'b0,
            "zero_ctl", g,
            32'({i_gnt[g], d_gnt[g], i_rv[g], d_rv[g], m_cs[g], m_we[g], busy[g]}), 32'h0);
        chk(i_rd[g] == 32'h0 && d_rd[g] == 32'h0, "zero_rdata", g, i_rd[g] | d_rd[g], 32'h0);
        chk(m_addr[g] == 32'h0 && m_wdata[g] == 32'h0, "zero_mem", g,
            m_addr[g] | m_wdata[g], 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        bit ei, ed;
        for (int g = 0; g < N; g++) begin
            i_req[g] = 1'b0; i_addr[g] = '0; d_req[g] = 1'b0; d_we[g] = 1'b0;
            d_addr[g] = '0; d_wdata[g] = '0;
        end

        // Reset state
        nxt();
        #1;
        for (int g = 0; g < N; g++) check_zero(g);
        nxt();
        rst = 1'b0;
        nxt();

        // Both requesters hold loads, L = 2: grants alternate D, I, D, I
        i_req[1] = 1'b1; i_addr[1] = 32'h100;
        d_req[1] = 1'b1; d_addr[1] = 32'h200; d_we[1] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) nxt();
            if (k == 16) begin
                i_req[1] = 1'b0;
                d_req[1] = 1'b0;
            end
            #1;
            ed = (k % 5 == 0) && (k < 16) && ((k / 5) % 2 == 0);
            ei = (k % 5 == 0) && (k < 16) && ((k / 5) % 2 == 1);
            chk(i_gnt[1] == ei, "alt_i_gnt", 1, 32'(i_gnt[1]), 32'(ei));
            chk(d_gnt[1] == ed, "alt_d_gnt", 1, 32'(d_gnt[1]), 32'(ed));
            if (ed) begin
                cmd_q.push_back(cmd_t'{1, 1'b0, 32'h200, 32'h0, cyc + 1});
                rv_q.push_back(rv_t'{1, 1'b1, memf(32'h200), cyc + 4});
            end
            if (ei) begin
                cmd_q.push_back(cmd_t'{1, 1'b0, 32'h100, 32'h0, cyc + 1});
                rv_q.push_back(rv_t'{1, 1'b0, memf(32'h100), cyc + 4});
            end
        end
        repeat (2) nxt();

        // Fetch only, L = 1
        i_req[0] = 1'b1; i_addr[0] = 32'h10;
        #1;
        chk(i_gnt[0] == 1'b1, "fetch_gnt", 0, 32'(i_gnt[0]), 32'h1);
        t0 = cyc;
        cmd_q.push_back(cmd_t'{0, 1'b0, 32'h10, 32'h0, t0 + 1});
        rv_q.push_back(rv_t'{0, 1'b0, 32'h8C010004, t0 + 3});
        nxt();
        i_req[0] = 1'b0;
        #1;
        chk(busy[0] == 1'b1, "fetch_busy", 0, 32'(busy[0]), 32'h1);
        repeat (3) nxt();
        #1;
        chk(busy[0] == 1'b0, "fetch_idle", 0, 32'(busy[0]), 32'h0);

        // Store only, then a new grant two cycles after the store grant
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h40; d_wdata[0] = 32'hDEADBEEF;
        #1;
        chk(d_gnt[0] == 1'b1, "store_gnt", 0, 32'(d_gnt[0]), 32'h1);
        t0 = cyc;
        cmd_q.push_back(cmd_t'{0, 1'b1, 32'h40, 32'hDEADBEEF, t0 + 1});
        nxt();
        d_req[0] = 1'b0; d_we[0] = 1'b0; d_wdata[0] = '0;
        nxt();
        i_req[0] = 1'b1; i_addr[0] = 32'h20;
        #1;
        chk(i_gnt[0] == 1'b1, "store_next_gnt", 0, 32'(i_gnt[0]), 32'h1);
        cmd_q.push_back(cmd_t'{0, 1'b0, 32'h20, 32'h0, t0 + 3});
        rv_q.push_back(rv_t'{0, 1'b0, memf(32'h20), t0 + 5});
        nxt();
        i_req[0] = 1'b0;
        repeat (5) nxt();

        // MEM_LAT = 7 load; requests raised while busy and dropped before
        // IDLE must get no grant and cause no memory access
        d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'h300;
        #1;
        chk(d_gnt[2] == 1'b1, "lat7_gnt", 2, 32'(d_gnt[2]), 32'h1);
        t0 = cyc;
        cmd_q.push_back(cmd_t'{2, 1'b0, 32'h300, 32'h0, t0 + 1});
        rv_q.push_back(rv_t'{2, 1'b1, memf(32'h300), t0 + 9});
        for (int k = 1; k <= 9; k++) begin
            nxt();
            if (k == 1) begin
                i_req[2] = 1'b1; i_addr[2] = 32'h3A0; d_addr[2] = 32'h3C0;
            end
            #1;
            chk(!i_gnt[2] && !d_gnt[2], "lat7_no_gnt", 2, 32'({i_gnt[2], d_gnt[2]}), 32'h0);
            chk(busy[2] == 1'b1, "lat7_busy", 2, 32'(busy[2]), 32'h1);
        end
        i_req[2] = 1'b0; d_req[2] = 1'b0;
        nxt();
        #1;
        chk(busy[2] == 1'b0 && !i_gnt[2] && !d_gnt[2], "dropped_no_gnt", 2,
            32'({busy[2], i_gnt[2], d_gnt[2]}), 32'h0);
        nxt();

        // Reset asserted during WAIT abandons the access
        d_req[2] = 1'b1; d_addr[2] = 32'h380;
        #1;
        chk(d_gnt[2] == 1'b1, "rst_case_gnt", 2, 32'(d_gnt[2]), 32'h1);
        t0 = cyc;
        cmd_q.push_back(cmd_t'{2, 1'b0, 32'h380, 32'h0, t0 + 1});
        nxt();
        d_req[2] = 1'b0;
        repeat (2) nxt();
        rst = 1'b1;
        i_req[2] = 1'b1; i_addr[2] = 32'h3E0;
        #1;
        check_zero(2);
        nxt();
        #1;
        check_zero(2);
        rst = 1'b0;
        d_req[2] = 1'b1; d_addr[2] = 32'h3F0;
        #1;
        chk(d_gnt[2] == 1'b1 && i_gnt[2] == 1'b0, "post_rst_data_first", 2,
            32'({i_gnt[2], d_gnt[2]}), 32'h1);
        cmd_q.push_back(cmd_t'{2, 1'b0, 32'h3F0, 32'h0, cyc + 1});
        rv_q.push_back(rv_t'{2, 1'b1, memf(32'h3F0), cyc + 9});
        nxt();
        i_req[2] = 1'b0; d_req[2] = 1'b0;
        repeat (12) nxt();

        chk(cmd_q.size() == 0, "cmd_pending", 0, 32'(cmd_q.size()), 32'h0);
        chk(rv_q.size() == 0, "rv_pending", 0, 32'(rv_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-port synchronous memory between the multicycle core's instruction-fetch port and its load/store port. It sits between the core and a unified instruction/data memory. It serialises accesses, one outstanding at a time, with round-robin priority on conflict. It returns read data after a parameterised memory latency.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- MEM_LAT, 1, memory read latency in cycles (legal 1..7), counted from the cycle o_m_cs is high
- i_clk  input  1  single clock, all logic on rising edge
- i_rst  input  1  reset; one clock; reset is asynchronous and active-high
- i_i_req  input  1  instruction fetch request, held until granted
- i_i_addr  input  ADDR_WIDTH  fetch byte address
- o_i_gnt  output  1  fetch request accepted this cycle
- o_i_rvalid  output  1  one-cycle pulse, o_i_rdata valid
- o_i_rdata  output  DATA_WIDTH  fetched instruction
- i_d_req  input  1  data request, held until granted
- i_d_we  input  1  1 = store, 0 = load
- i_d_addr  input  ADDR_WIDTH  data byte address
- i_d_wdata  input  DATA_WIDTH  store data
- o_d_gnt  output  1  data request accepted this cycle
- o_d_rvalid  output  1  one-cycle pulse, o_d_rdata valid (loads only)
- o_d_rdata  output  DATA_WIDTH  load data
- o_m_cs  output  1  memory command strobe
- o_m_we  output  1  memory write enable, qualified by o_m_cs
- o_m_addr  output  ADDR_WIDTH  memory address, passed through unmodified
- o_m_wdata  output  DATA_WIDTH  memory write data
- i_m_rdata  input  DATA_WIDTH  memory read data
- o_busy  output  1  high in every state except IDLE

## Operation
- FSM states are IDLE, ACCESS, WAIT and RESP.
- IDLE: gnt is combinational, from the current requests and the last_r pointer.
  - Only one request: grant it.
  - Both requests: grant the requester that was not served last.
  - last_r resets to INST, so the first conflict goes to data.
  - On the grant edge, latch addr, we, wdata and the requester ID, update last_r, and go to ACCESS.
- ACCESS: o_m_cs = 1 and o_m_* are driven from the latched registers for exactly one cycle.
  - Store: go to IDLE. There is no rvalid for a store.
  - Load: load cnt = MEM_LAT-1 and go to WAIT.
- WAIT: decrement cnt each cycle.
  - When cnt == 0, i_m_rdata is valid. Capture it into the rdata register of the latched requester, then go to RESP.
- RESP: pulse that requester's rvalid for one cycle, then go to IDLE.
- No grant is issued outside IDLE. Requests raised in other states wait.
- A request dropped before it is granted has no effect.
- rdata registers hold their last value until the next capture.
- o_m_we, o_m_addr and o_m_wdata are 0 whenever o_m_cs = 0.
- Reset, including reset mid-operation:
  - state = IDLE, last_r = INST, cnt = 0.
  - All outputs = 0.
  - Any in-flight access is abandoned and no rvalid is issued for it.

## Timing
- Load with MEM_LAT = L:
  - gnt in cycle 0.
  - o_m_cs in cycle 1.
  - i_m_rdata sampled at the end of cycle 1+L.
  - rvalid in cycle 2+L.
  - Next grant possible in cycle 3+L.
- Store: gnt in cycle 0, o_m_cs/o_m_we in cycle 1, next grant possible in cycle 2.
- Back-to-back conflicting requests alternate strictly: D, I, D, I, ...
- Reset values:
  - o_i_gnt = o_d_gnt = 0
  - o_i_rvalid = o_d_rvalid = 0
  - o_i_rdata = o_d_rdata = 0
  - o_m_cs = o_m_we = 0, o_m_addr = 0, o_m_wdata = 0
  - o_busy = 0

## Structure
- The shared package holds:
  - FSM state encoding (IDLE, ACCESS, WAIT, RESP, 2 bits).
  - Requester ID constants (REQ_INST = 0, REQ_DATA = 1).
  - MEM_LAT bounds; cnt is 3 bits.
- Sub-module rr_arb2: combinational two-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: one-hot gnt[1:0] and winner ID.
- The FSM, latches and counter stay in mem_arbiter.

## Test plan
- Fetch only, L = 1, i_i_addr = 0x10, memory returns 0x8C010004:
  - gnt in cycle 0, o_m_cs with addr 0x10 in cycle 1.
  - o_i_rvalid with 0x8C010004 in cycle 3, o_busy low in cycle 4.
- Store only, i_d_addr = 0x40, i_d_wdata = 0xDEADBEEF:
  - o_m_cs = o_m_we = 1 with 0x40/0xDEADBEEF in cycle 1.
  - No o_d_rvalid; new grant possible in cycle 2.
- Both requests held continuously after reset (loads), L = 2:
  - Grants alternate D, I, D, I.
  - Each rvalid appears 4 cycles after its grant and only on the granted port.
- MEM_LAT = 7 load: exactly 7 WAIT cycles; o_d_rvalid in cycle 9; no grant from cycle 1 to cycle 9.
- i_rst asserted in WAIT:
  - All outputs 0 immediately; no rvalid for the abandoned access.
  - After release, a conflicting request is granted to data first.
- Request dropped while the arbiter is busy: no grant is issued for it and no memory access occurs.
